// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the countdown timer peripheral.
package timer_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/countdown_timer.sv
// Programmable down-counter with one-shot/auto-reload modes and a sticky
// expiry interrupt plus an overrun (missed) flag.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             tick,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count_out,
  output logic             irq,
  output logic             missed,
  output logic             running
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             irq_q, irq_d;
  logic             missed_q, missed_d;

  logic dec, expire, set_irq;

  assign dec     = (state_q == ST_RUN) && enable && tick;
  assign expire  = dec && (count_q == WIDTH'(1));
  // A load in the expiry cycle pre-empts the expiry entirely.
  assign set_irq = expire && !load;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? ST_RUN : ST_IDLE;
    end else if (dec) begin
      if (count_q == WIDTH'(1)) begin
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Set beats acknowledge; an ack alongside an expiry also suppresses missed.
  always_comb begin
    irq_d    = irq_q;
    missed_d = missed_q;
    if (set_irq)      irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
    if (irq_ack)                missed_d = 1'b0;
    else if (set_irq && irq_q)  missed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      irq_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      irq_q    <= irq_d;
      missed_q <= missed_d;
    end
  end

  assign count_out = count_q;
  assign irq       = irq_q;
  assign missed    = missed_q;
  assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic         enable;
  logic         tick;
  logic         irq_ack;
  logic [W-1:0] count_out;
  logic         irq;
  logic         missed;
  logic         running;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .enable      (enable),
    .tick        (tick),
    .irq_ack     (irq_ack),
    .count_out   (count_out),
    .irq         (irq),
    .missed      (missed),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input bit i, input bit m, input bit r);
    chk({tag, ".count"},   64'(count_out), 64'(c));
    chk({tag, ".irq"},     64'(irq),       64'(i));
    chk({tag, ".missed"},  64'(missed),    64'(m));
    chk({tag, ".running"}, 64'(running),   64'(r));
  endtask

  initial begin
    rst_n = 1'b0; load = 0; load_value = '0; auto_reload = 0;
    enable = 0; tick = 0; irq_ack = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step();

    // One-shot, load 5, tick every cycle
    load = 1; load_value = 5; auto_reload = 0; enable = 1; tick = 1;
    step(); load = 0;
    chk_all("os.load", 5, 0, 0, 1);
    step(); chk_all("os.4", 4, 0, 0, 1);
    step(); chk_all("os.3", 3, 0, 0, 1);
    step(); chk_all("os.2", 2, 0, 0, 1);
    step(); chk_all("os.1", 1, 0, 0, 1);
    step(); chk_all("os.exp", 0, 1, 0, 0);
    step(); step();
    chk_all("os.hold", 0, 1, 0, 0);
    irq_ack = 1; step(); irq_ack = 0;
    chk_all("os.ack", 0, 0, 0, 0);

    // Auto-reload, load 3
    load = 1; load_value = 3; auto_reload = 1;
    step(); load = 0;
    chk_all("ar.load", 3, 0, 0, 1);
    step(); chk_all("ar.2", 2, 0, 0, 1);
    step(); chk_all("ar.1", 1, 0, 0, 1);
    step(); chk_all("ar.exp1", 3, 1, 0, 1);
    step(); chk_all("ar.2b", 2, 1, 0, 1);
    step(); chk_all("ar.1b", 1, 1, 0, 1);
    step(); chk_all("ar.exp2", 3, 1, 1, 1);
    irq_ack = 1; step(); irq_ack = 0;
    chk_all("ar.ack", 2, 0, 0, 1);

    // Sparse ticks with an enable pause, one-shot load 4
    load = 1; load_value = 4; auto_reload = 0; tick = 0;
    step(); load = 0;
    chk_all("en.load", 4, 0, 0, 1);
    tick = 1; step(); chk_all("en.t1", 3, 0, 0, 1);
    tick = 0; step(); chk_all("en.gap1", 3, 0, 0, 1);
    tick = 1; step(); chk_all("en.t2", 2, 0, 0, 1);
    enable = 0;
    step(); step(); step();
    chk_all("en.pause", 2, 0, 0, 1);
    enable = 1;
    step(); chk_all("en.t3", 1, 0, 0, 1);
    tick = 0; step(); chk_all("en.gap3", 1, 0, 0, 1);
    tick = 1; step(); chk_all("en.t4", 0, 1, 0, 0);

    // Load keeps the pending irq; expiry with ack keeps irq and no missed
    load = 1; load_value = 2;
    step(); load = 0;
    chk_all("ack.load", 2, 1, 0, 1);
    step(); chk_all("ack.1", 1, 1, 0, 1);
    irq_ack = 1; step(); irq_ack = 0;
    chk_all("ack.exp", 0, 1, 0, 0);
    irq_ack = 1; step(); irq_ack = 0;
    chk_all("ack.clr", 0, 0, 0, 0);

    // Load in the expiry cycle wins
    load = 1; load_value = 3;
    step(); load = 0;
    step(); step();
    chk_all("lx.1", 1, 0, 0, 1);
    load = 1; load_value = 7;
    step(); load = 0;
    chk_all("lx.load", 7, 0, 0, 1);
    step(); chk_all("lx.6", 6, 0, 0, 1);

    // Load 0 parks in IDLE
    load = 1; load_value = 0;
    step(); load = 0;
    repeat (10) step();
    chk_all("zero", 0, 0, 0, 0);

    // Async reset mid-count
    load = 1; load_value = 100;
    step(); load = 0;
    repeat (10) step();
    chk_all("rst.pre", 90, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    repeat (110) step();
    chk_all("rst.after", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
